peek_port_arbiter: RTL and testbench
====================================

// Module: peek_port_arbiter
// PURPOSE
// Shares the single debug peek port of noc_with_cores (peek_id/peek_addr -> peek_data) between two readers:
// port 0 = VGA scan-out (real-time, priority), port 1 = UART memory dump (background, starvation-protected).
// Fully pipelined, one granted read per cycle; each grant returns exactly one tagged response, in order.
// PARAMETERS
// ID_W       4   width of core/memory id (= $clog2(`RN))
// ADDR_W     32  peek word address width
// DATA_W     32  peek data width
// PEEK_LAT   1   cycles from peek_id/peek_addr driven to peek_data valid (0 = combinational)
// STARVE_MAX 8   consecutive denied cycles of port 1 before it is forced a slot (>=1)
// IDLE_ID    15  id driven on peek port when no read is issued
// PORTS
// clk        in   1       system clock
// rst_n      in   1       asynchronous active-low reset
// r0_req     in   1       port 0 read request, held until r0_gnt
// r0_id      in   ID_W    port 0 target id, stable while r0_req
// r0_addr    in   ADDR_W  port 0 word address, stable while r0_req
// r0_gnt     out  1       port 0 request accepted this cycle
// r0_rvalid  out  1       port 0 response valid (1-cycle pulse)
// r0_rdata   out  DATA_W  port 0 response data
// r1_req/r1_id/r1_addr/r1_gnt/r1_rvalid/r1_rdata  same as port 0, for port 1
// peek_id    out  ID_W    to noc_with_cores
// peek_addr  out  ADDR_W  to noc_with_cores
// peek_data  in   DATA_W  from noc_with_cores
// BEHAVIOUR
// - Reset: gnt=0, rvalid=0, rdata=0, peek_id=IDLE_ID, peek_addr=0, mode=NORMAL, starve_cnt=0, pipeline empty.
// - Grants combinational from req/mode; at most one gnt per cycle; gnt only when matching req is high.
// - mode NORMAL: r0_req -> r0_gnt; else r1_req -> r1_gnt.
//   starve_cnt++ (saturating) each cycle r1_req && !r1_gnt; cleared on r1_gnt or !r1_req.
//   starve_cnt == STARVE_MAX-1 while incrementing -> next mode FORCE.
// - mode FORCE: r1_req -> r1_gnt (r0 denied, holds), then NORMAL, starve_cnt=0.
//   r1_req low in FORCE (protocol violation) -> NORMAL, no grant.
// - Issue: grant in cycle t registers {id,addr} onto peek port for cycle t+1; no grant ->
//   peek_id=IDLE_ID, peek_addr=0 in t+1. Owner tag + valid enter a delay line of PEEK_LAT+1 stages.
// - Return: peek_data sampled at end of cycle t+1+PEEK_LAT into owner's rdata; rxx_rvalid high
//   in cycle t+2+PEEK_LAT (default: grant t -> rvalid t+3). Non-owner rdata holds last value.
// - Back-to-back grants to alternating ports return in grant order, one per cycle, no bubbles.
// - Same-cycle requests from both ports: NORMAL -> port 0; FORCE -> port 1.
// - Reset mid-operation: in-flight reads discarded; no rvalid for any pre-reset grant.
// - No backpressure on responses: requester must accept rvalid every cycle.
// STRUCTURE
// - noc_peek_pkg: typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_mode_t;
//   typedef enum logic {OWN_P0, OWN_P1} peek_owner_t; struct {logic vld; peek_owner_t own;} peek_tag_t.
// - Sub-module peek_resp_pipe: parameterised shift register of peek_tag_t, depth PEEK_LAT+1,
//   async reset to empty; arbiter instantiates it and performs data capture/demux.
// TESTING
// - Reset: hold rst_n=0 with both req=1 -> no gnt, peek_id=15, peek_addr=0, rvalid=0.
// - Single port-0 read id=6 addr=5, peek model returns 0xA5 -> r0_gnt at t, peek_id=6/addr=5 at t+1, r0_rvalid, r0_rdata=0xA5 at t+3.
// - r0_req held continuously, r1_req held -> r1_gnt exactly once every STARVE_MAX+1 cycles (9 with defaults).
// - Alternating grants P0,P1,P0 addrs 1,2,3 -> rvalids in order on correct ports, consecutive cycles, data=f(addr).
// - Assert rst_n=0 for 1 cycle one cycle after grant -> no rvalid ever for that read; state back to NORMAL.
// - PEEK_LAT=0 build: grant t -> rvalid t+2; PEEK_LAT=3 build: grant t -> rvalid t+5.

Source files
------------

// File: rtl/noc_peek_pkg.sv
// Shared types for the peek-port arbiter: arbitration mode, response owner
// and the tag that travels alongside each issued peek read.
package noc_peek_pkg;

  typedef enum logic {ARB_NORMAL, ARB_FORCE} arb_mode_t;
  typedef enum logic {OWN_P0, OWN_P1} peek_owner_t;

  typedef struct packed {
    logic        vld;
    peek_owner_t own;
  } peek_tag_t;

  localparam peek_tag_t TAG_EMPTY = '{vld: 1'b0, own: OWN_P0};

endpackage

// File: rtl/peek_port_arbiter_if.sv
// One reader's request/grant/response bundle; the reader is the master,
// the arbiter is the slave.
interface peek_port_arbiter_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ID_W-1:0]   id;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, id, addr, input gnt, rvalid, rdata);
  modport slave  (input req, id, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/peek_port_arbiter_resp_pipe.sv
// Delay line carrying the owner tag of each issued peek read until its
// data is valid on peek_data.
module peek_resp_pipe
  import noc_peek_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  peek_tag_t tag_in,
  output peek_tag_t tag_out
);

  peek_tag_t stage [DEPTH];

  // NOTE: every stage is reset, not just the data path, so a reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_EMPTY;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/peek_port_arbiter.sv
// Shares the single debug peek port between the VGA reader (port 0, priority)
// and the UART dump reader (port 1, forced a slot after STARVE_MAX denials).
module peek_port_arbiter
  import noc_peek_pkg::*;
#(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PEEK_LAT   = 1,
  parameter int STARVE_MAX = 8,
  parameter int IDLE_ID    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  peek_port_arbiter_if.slave r0,
  peek_port_arbiter_if.slave r1,
  output logic [ID_W-1:0]   peek_id,
  output logic [ADDR_W-1:0] peek_addr,
  input  logic [DATA_W-1:0] peek_data
);

  localparam int             CNT_W    = $clog2(STARVE_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  arb_mode_t         mode, mode_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_nxt;
  logic              gnt0, gnt1;
  peek_tag_t         tag_in, tag_out;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mode_nxt   = mode;
    starve_nxt = starve_cnt;
    if (rst_n) begin
      case (mode)
        ARB_NORMAL: begin
          gnt0 = r0.req;
          gnt1 = !r0.req && r1.req;
          if (r1.req && !gnt1) begin
            if (starve_cnt == CNT_LAST) mode_nxt = ARB_FORCE;
            else                         starve_nxt = starve_cnt + 1'b1;
          end else begin
            starve_nxt = '0;
          end
        end
        ARB_FORCE: begin
          // Port 0 is held off; a dropped r1_req just returns to NORMAL.
          gnt1       = r1.req;
          mode_nxt   = ARB_NORMAL;
          starve_nxt = '0;
        end
        default: begin
          mode_nxt   = ARB_NORMAL;
          starve_nxt = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode       <= ARB_NORMAL;
      starve_cnt <= '0;
    end else begin
      mode       <= mode_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peek_id   <= ID_W'(IDLE_ID);
      peek_addr <= '0;
    end else if (gnt0) begin
      peek_id   <= r0.id;
      peek_addr <= r0.addr;
    end else if (gnt1) begin
      peek_id   <= r1.id;
      peek_addr <= r1.addr;
    end else begin
      peek_id   <= ID_W'(IDLE_ID);
      peek_addr <= '0;
    end
  end

  assign tag_in = '{vld: gnt0 | gnt1, own: gnt1 ? OWN_P1 : OWN_P0};

  peek_resp_pipe #(.DEPTH(PEEK_LAT + 1)) u_resp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // The tag leaves the pipe in the cycle its data is on peek_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= tag_out.vld && (tag_out.own == OWN_P0);
      rvalid1 <= tag_out.vld && (tag_out.own == OWN_P1);
      if (tag_out.vld && tag_out.own == OWN_P0) rdata0 <= peek_data;
      if (tag_out.vld && tag_out.own == OWN_P1) rdata1 <= peek_data;
    end
  end

  assign r0.gnt    = gnt0;
  assign r1.gnt    = gnt1;
  assign r0.rvalid = rvalid0;
  assign r1.rvalid = rvalid1;
  assign r0.rdata  = rdata0;
  assign r1.rdata  = rdata1;

endmodule

// File: tb/tb_peek_port_arbiter.sv
// Directed bench for peek_port_arbiter: grants checked per cycle, responses
// checked against a scoreboard of expected {port, data, cycle}.
module tb_peek_port_arbiter;

  localparam int ID_W       = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int PEEK_LAT   = 1;
  localparam int STARVE_MAX = 8;
  localparam int IDLE_ID    = 15;
  localparam int RET_LAT    = PEEK_LAT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  peek_port_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
  peek_port_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();

  logic [ID_W-1:0]   peek_id;
  logic [ADDR_W-1:0] peek_addr;
  logic [DATA_W-1:0] peek_data;

  peek_port_arbiter #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .PEEK_LAT(PEEK_LAT), .STARVE_MAX(STARVE_MAX), .IDLE_ID(IDLE_ID)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r0        (r0_if),
    .r1        (r1_if),
    .peek_id   (peek_id),
    .peek_addr (peek_addr),
    .peek_data (peek_data)
  );

  function automatic logic [31:0] mem_f(input logic [3:0] id, input logic [31:0] a);
    return 32'hA5 + ((a ^ 32'd5) << 8) + (32'(id ^ 4'd6) << 20);
  endfunction

  // One-cycle-latency memory model behind the peek port.
  always @(posedge clk) peek_data <= mem_f(peek_id, peek_addr);

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] d);
    exp_t e;
    e.port = port;
    e.data = d;
    e.due  = cyc + RET_LAT;
    sb.push_back(e);
  endtask

  // Response monitor: every rvalid must match the oldest expected read, on time.
  always @(negedge clk) begin
    if (r0_if.rvalid || r1_if.rvalid) begin
      if (sb.size() == 0) begin
        check("spurious_rvalid", {r1_if.rvalid, r0_if.rvalid}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rvalid_port", {r1_if.rvalid, r0_if.rvalid}, e.port ? 2'b10 : 2'b01);
        check("rdata", e.port ? r1_if.rdata : r0_if.rdata, e.data);
        check("rvalid_cycle", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("missing_rvalid", {r1_if.rvalid, r0_if.rvalid}, e.port ? 2'b10 : 2'b01);
    end
  end

  // Drive one cycle of requests, check grants mid-cycle, log expected responses.
  task automatic drive(input logic q0, input logic [3:0] i0, input logic [31:0] a0,
                       input logic q1, input logic [3:0] i1, input logic [31:0] a1,
                       input logic e0, input logic e1);
    r0_if.req = q0; r0_if.id = i0; r0_if.addr = a0;
    r1_if.req = q1; r1_if.id = i1; r1_if.addr = a1;
    @(negedge clk);
    check("r0_gnt", r0_if.gnt, e0);
    check("r1_gnt", r1_if.gnt, e1);
    if (e0) push(1'b0, mem_f(i0, a0));
    if (e1) push(1'b1, mem_f(i1, a1));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    r0_if.req = 1'b1; r0_if.id = 4'd3; r0_if.addr = 32'd9;
    r1_if.req = 1'b1; r1_if.id = 4'd4; r1_if.addr = 32'd8;

    // Reset held with both ports requesting.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_r0_gnt", r0_if.gnt, 1'b0);
      check("rst_r1_gnt", r1_if.gnt, 1'b0);
      check("rst_peek_id", peek_id, 4'd15);
      check("rst_peek_addr", peek_addr, 32'd0);
      check("rst_rvalid", {r1_if.rvalid, r0_if.rvalid}, 2'b00);
      check("rst_rdata", {r1_if.rdata, r0_if.rdata}, 64'd0);
    end
    r0_if.req = 1'b0;
    r1_if.req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single port-0 read, id 6 addr 5 -> 0xA5.
    drive(1'b1, 4'd6, 32'd5, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    check("issue_peek_id", peek_id, 4'd6);
    check("issue_peek_addr", peek_addr, 32'd5);
    idle(4);
    check("r0_rdata_hold", r0_if.rdata, 32'hA5);
    check("r1_rdata_untouched", r1_if.rdata, 32'd0);

    // Alternating owners back to back.
    drive(1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'd2, 1'b0, 1'b1);
    drive(1'b1, 4'd4, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    idle(5);
    check("r0_rdata_last", r0_if.rdata, mem_f(4'd4, 32'd3));
    check("r1_rdata_last", r1_if.rdata, mem_f(4'd3, 32'd2));

    // Both ports saturated: port 1 wins one slot in every STARVE_MAX+1.
    for (int k = 0; k < 3 * (STARVE_MAX + 1); k++) begin
      logic slot1;
      slot1 = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      drive(1'b1, 4'd9, 32'(k), 1'b1, 4'd10, 32'd100, !slot1, slot1);
    end
    idle(5);

    // Reset one cycle after a grant discards the read.
    drive(1'b1, 4'd7, 32'd20, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_peek_id", peek_id, 4'd15);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(6);

    // Back in NORMAL: contention goes to port 0, then port 1 alone.
    drive(1'b1, 4'd1, 32'd1, 1'b1, 4'd2, 32'd2, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 32'd2, 1'b0, 1'b1);
    idle(5);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
